// File: rtl/locker_arbiter.sv
// ---------------------------------------------------------------------------
// locker_arbiter
//
// Clocked N-channel mutual-exclusion arbiter for four-phase req/ack channels.
// One producer at a time owns the shared resource. The lock is held for the
// whole four-phase cycle: request, acknowledge, release, unlock.
//
// Optional feature macro: LOCKER_ARB_RR_EN
//   defined     -> round-robin selection. The search starts at a pointer that
//                  moves to the slot after the owner on every release.
//   not defined -> fixed priority. The lowest requesting index always wins,
//                  and no pointer state exists.
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module locker_arbiter #(
    parameter int SIZE  = 2,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  req_in,
    input  logic [SIZE-1:0]  ack_out,
    output logic [SIZE-1:0]  req_out,
    output logic [SIZE-1:0]  ack_in,
    output logic             busy,
    output logic [IDX_W-1:0] owner,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [SIZE-1:0]  r_reqOut;
    logic [SIZE-1:0]  w_reqOutNext;
    logic [SIZE-1:0]  r_ackIn;
    logic [SIZE-1:0]  w_ackInNext;
    logic             r_busy;
    logic             w_busyNext;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_ownerNext;
    logic             r_err;
    logic             w_errDetect;

    logic [SIZE-1:0]  w_ownerMask;
    logic             w_ownerAck;
    logic             w_ownerReq;
    logic [IDX_W-1:0] w_winner;
    logic             w_winnerValid;

`ifdef LOCKER_ARB_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptrNext;
    logic [IDX_W-1:0] w_ownerPlusOne;
`endif

    // One-hot mask of the current owner, and the owner's own channel bits.
    assign w_ownerMask = SIZE'(1) << r_owner;
    assign w_ownerAck  = |(ack_out & w_ownerMask);
    assign w_ownerReq  = |(req_in & w_ownerMask);

    // Find the first requester. The scan starts at the pointer in round-robin mode and at index 0 otherwise.
    always_comb begin
        int idx;
        w_winner      = '0;
        w_winnerValid = 1'b0;
        idx           = 0;
        for (int i = 0; i < SIZE; i++) begin
`ifdef LOCKER_ARB_RR_EN
            idx = int'(r_ptr) + i;
            if (idx >= SIZE) begin
                idx = idx - SIZE;
            end
`else
            idx = i;
`endif
            if (!w_winnerValid && ((req_in & (SIZE'(1) << idx)) != '0)) begin
                w_winner      = IDX_W'(idx);
                w_winnerValid = 1'b1;
            end
        end
    end

    // Flag acknowledges from channels that do not hold the lock. In IDLE, no channel may acknowledge.
    always_comb begin
        w_errDetect = 1'b0;
        if (r_state == IDLE) begin
            w_errDetect = |ack_out;
        end else begin
            w_errDetect = |(ack_out & ~w_ownerMask);
        end
    end

`ifdef LOCKER_ARB_RR_EN
    // Slot after the owner, wrapping from SIZE-1 back to 0. Also correct when SIZE is not a power of two.
    always_comb begin
        w_ownerPlusOne = '0;
        if (r_owner != IDX_W'(SIZE - 1)) begin
            w_ownerPlusOne = r_owner + IDX_W'(1);
        end
    end
`endif

    // Next-state and next-output logic. A protocol violation freezes the lock state for that cycle.
    always_comb begin
        w_stateNext  = r_state;
        w_reqOutNext = r_reqOut;
        w_ackInNext  = r_ackIn;
        w_busyNext   = r_busy;
        w_ownerNext  = r_owner;
`ifdef LOCKER_ARB_RR_EN
        w_ptrNext    = r_ptr;
`endif
        if (!w_errDetect) begin
            case (r_state)
                IDLE: begin
                    if (w_winnerValid) begin
                        w_reqOutNext = SIZE'(1) << w_winner;
                        w_ownerNext  = w_winner;
                        w_busyNext   = 1'b1;
                        w_stateNext  = REQ;
                    end
                end
                REQ: begin
                    if (w_ownerAck) begin
                        w_ackInNext = w_ownerMask;
                        w_stateNext = ACK;
                    end
                end
                ACK: begin
                    if (!w_ownerReq) begin
                        w_reqOutNext = '0;
                        w_stateNext  = REL;
                    end
                end
                REL: begin
                    if (!w_ownerAck) begin
                        w_ackInNext = '0;
                        w_busyNext  = 1'b0;
`ifdef LOCKER_ARB_RR_EN
                        w_ptrNext   = w_ownerPlusOne;
`endif
                        w_stateNext = IDLE;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // State and output registers. Reset drops any grant at once, with no release handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_reqOut <= '0;
            r_ackIn  <= '0;
            r_busy   <= 1'b0;
            r_owner  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_reqOut <= w_reqOutNext;
            r_ackIn  <= w_ackInNext;
            r_busy   <= w_busyNext;
            r_owner  <= w_ownerNext;
            r_err    <= w_errDetect;
        end
    end

`ifdef LOCKER_ARB_RR_EN
    // Round-robin pointer. It moves only when a lock is released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptrNext;
        end
    end
`endif

    assign req_out = r_reqOut;
    assign ack_in  = r_ackIn;
    assign busy    = r_busy;
    assign owner   = r_owner;
    assign err     = r_err;

endmodule

// File: tb/tb_locker_arbiter.sv
// ---------------------------------------------------------------------------
// tb_locker_arbiter
//
// Directed bench for locker_arbiter with SIZE=4.
// Expected values are worked out by hand for each step.
// The contention section adapts to LOCKER_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_locker_arbiter;

    localparam int SIZE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] ack_out;
    logic [3:0] req_out;
    logic [3:0] ack_in;
    logic       busy;
    logic [1:0] owner;
    logic       err;

    int vecCount  = 0;
    int missCount = 0;

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    locker_arbiter #(.SIZE(SIZE)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .ack_out (ack_out),
        .req_out (req_out),
        .ack_in  (ack_in),
        .busy    (busy),
        .owner   (owner),
        .err     (err)
    );

    // Drive the inputs, then move to 1 unit after the next rising edge.
    task automatic applyStimulus(input logic rstVal, input logic [3:0] reqVal, input logic [3:0] ackVal);
        rst     = rstVal;
        req_in  = reqVal;
        ack_out = ackVal;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expReq, input logic [3:0] expAck,
                            input logic expBusy, input logic [1:0] expOwner, input logic expErr);
        checkOutput({tag, ".req_out"}, 32'(req_out), 32'(expReq));
        checkOutput({tag, ".ack_in"},  32'(ack_in),  32'(expAck));
        checkOutput({tag, ".busy"},    32'(busy),    32'(expBusy));
        checkOutput({tag, ".owner"},   32'(owner),   32'(expOwner));
        checkOutput({tag, ".err"},     32'(err),     32'(expErr));
    endtask

    // One full four-phase transaction. The responsive environment acknowledges the expected owner.
    task automatic runTransaction(input string tag, input logic [3:0] reqHold, input logic [1:0] expOwner);
        logic [3:0] grantMask;
        grantMask = 4'b0001 << expOwner;
        applyStimulus(1'b1, reqHold, 4'b0000);
        checkAll({tag, ".grant"}, grantMask, 4'b0000, 1'b1, expOwner, 1'b0);
        applyStimulus(1'b1, reqHold, grantMask);
        checkAll({tag, ".ack"}, grantMask, grantMask, 1'b1, expOwner, 1'b0);
        applyStimulus(1'b1, reqHold & ~grantMask, grantMask);
        checkAll({tag, ".rel"}, 4'b0000, grantMask, 1'b1, expOwner, 1'b0);
        applyStimulus(1'b1, reqHold & ~grantMask, 4'b0000);
        checkAll({tag, ".unlock"}, 4'b0000, 4'b0000, 1'b0, expOwner, 1'b0);
    endtask

    initial begin
        // Reset state.
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        checkAll("reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Single request on channel 2. Afterwards the owner stays at 2 while idle.
        runTransaction("single", 4'b0100, 2'd2);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkAll("idle_hold", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);

        // Grant channel 3, then 0011 must go to channel 0.
        runTransaction("wrap_pre", 4'b1000, 2'd3);
        runTransaction("wrap", 4'b0011, 2'd0);

        // Protocol error while channel 1 owns the lock.
        applyStimulus(1'b1, 4'b0010, 4'b0000);
        checkAll("perr.grant", 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'b0010, 4'b0100);
        checkAll("perr.pulse", 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b1, 4'b0010, 4'b0000);
        checkAll("perr.clear", 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'b0010, 4'b0010);
        checkAll("perr.ack", 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0010);
        checkAll("perr.rel", 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkAll("perr.unlock", 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);

        // Reset while in ACK, then regrant one cycle after reset is released.
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        checkAll("rmid.grant", 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0001, 4'b0001);
        checkAll("rmid.ack", 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0000);
        checkAll("rmid.reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        checkAll("rmid.regrant", 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        checkAll("rmid.reset2", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Contention with every request held.
`ifdef LOCKER_ARB_RR_EN
        runTransaction("rr0", 4'b1111, 2'd0);
        runTransaction("rr1", 4'b1111, 2'd1);
        runTransaction("rr2", 4'b1111, 2'd2);
        runTransaction("rr3", 4'b1111, 2'd3);
        runTransaction("rr4", 4'b1111, 2'd0);
`else
        runTransaction("fp0", 4'b1010, 2'd1);
        runTransaction("fp1", 4'b1010, 2'd1);
        runTransaction("fp2", 4'b1010, 2'd1);
`endif

        // An acknowledge while IDLE pulses err and does not grant.
        applyStimulus(1'b1, 4'b0000, 4'b0001);
        checkOutput("idle_err.err", 32'(err), 32'd1);
        checkOutput("idle_err.busy", 32'(busy), 32'd0);
        checkOutput("idle_err.req_out", 32'(req_out), 32'd0);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkOutput("idle_err.clear", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/locker_arbiter.md
# locker_arbiter

Synchronous, parametrised N-channel mutual-exclusion arbiter for four-phase req/ack channels. It is the clocked successor of the per-channel locker array:
- grants exactly one requester at a time;
- holds the lock across the complete four-phase cycle;
- exposes owner/busy status;
- selects fairly among simultaneous requesters.

It sits between N requesting producers and one shared downstream resource in the arbitration path.

## Interface
Parameters:
- `SIZE`, 2: number of channels, ≥2.
- `IDX_W`, `$clog2(SIZE)`: width of owner index (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_in`  in  SIZE  per-channel request from producers.
- `ack_out`  in  SIZE  per-channel acknowledge from shared resource.
- `req_out`  out  SIZE  per-channel request forwarded to resource; at most one bit set.
- `ack_in`  out  SIZE  per-channel acknowledge returned to producer; at most one bit set.
- `busy`  out  1  lock held (state ≠ IDLE).
- `owner`  out  IDX_W  index of current/last granted channel.
- `err`  out  1  one-cycle pulse on protocol violation.

## Operation
- All outputs are registered.
- `rst`=0 at a rising edge clears:
  - `req_out`, `ack_in`, `busy`, `owner`, `err` to 0;
  - round-robin pointer `ptr` to 0;
  - state to IDLE.
- Reset mid-transaction abandons the grant immediately; no release handshake.
- FSM states and transitions:
  - IDLE: if `req_in`≠0, select winner w, set `req_out[w]`=1, `owner`=w, `busy`=1, go REQ. Otherwise stay.
  - REQ: when `ack_out[owner]`=1, set `ack_in[owner]`=1, go ACK.
  - ACK: when `req_in[owner]`=0, clear `req_out[owner]`, go REL.
  - REL: when `ack_out[owner]`=0, clear `ack_in[owner]` and `busy`, set `ptr`=(owner+1) mod SIZE (wraps SIZE-1→0), go IDLE.
- Non-owner `req_in` bits stay pending; they are neither forwarded nor acknowledged while `busy`=1.
- Winner selection: first set bit of `req_in` scanning from `ptr` upward with wrap (see Configuration).
- `err` pulses for one cycle, with no state change, when:
  - `ack_out[j]`=1 for any j≠owner while busy; or
  - `ack_out`≠0 in IDLE.
- A requester dropping `req_in[owner]` in REQ (before ack) is ignored until ACK; the handshake still completes.
- `owner` holds its value after release until the next grant.

## Timing
- Grant latency: `req_in` sampled high in IDLE at edge k → `req_out` high after edge k.
- Ack forwarding: `ack_out[owner]` sampled at edge k → `ack_in[owner]` high after edge k.
- Release: `req_in[owner]` low sampled at edge k → `req_out[owner]` low after edge k.
- Unlock: `ack_out[owner]` low sampled at edge k → `ack_in` and `busy` low after edge k.
- Earliest next grant is at edge k+1.
- Minimum full transaction with an immediately responsive environment: 4 cycles plus environment delays. Back-to-back grants need ≥1 IDLE cycle.
- Simultaneous requests in the same IDLE cycle resolve by the selection rule; losers wait.
- No combinational path from any input to any output.

## Configuration
- `LOCKER_ARB_RR_EN` defined: round-robin.
  - Search starts at `ptr`.
  - `ptr` advances on every release.
  - Starvation-free: a pending channel is granted within SIZE-1 foreign transactions.
- Not defined: fixed priority.
  - Lowest index wins.
  - `ptr` logic is removed; `ptr` reads constant 0.

## Test plan
All cases use SIZE=4.
- Single request: `req_in`=4'b0100 → `req_out`=4'b0100 one cycle later, `owner`=2, `busy`=1. Drive `ack_out[2]`=1 → `ack_in`=4'b0100 next cycle. Drop `req_in` → `req_out`=0. Drop `ack_out` → `ack_in`=0, `busy`=0.
- Contention, RR enabled: `req_in`=4'b1111 held, ack environment echoes immediately → grant order 0,1,2,3,0; `req_out` never has >1 bit set.
- Contention, RR disabled: `req_in`=4'b1010 held → channel 1 granted every transaction, channel 3 never.
- Wrap-around: after a grant to channel 3, `req_in`=4'b0011 → channel 0 granted (`ptr`=0).
- Protocol error: owner=1, drive `ack_out`=4'b0100 for one cycle → `err`=1 for exactly one cycle; `req_out`/`ack_in` unchanged.
- Reset mid-transaction in ACK state: `rst`=0 for one edge → all outputs 0 next cycle. With `req_in`=4'b0001 held, channel 0 is regranted one cycle after `rst` returns high.
